// File: rtl/conv_window_addr_gen.sv
// Convolution window address generator: walks the output map column, row, then plane
// and presents every tap address of one KHxKW window, with a pad mask, per transfer.
module conv_window_addr_gen #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_HEIGHT   = 35,
    parameter int DATA_WIDTH    = 35,
    parameter int DATA_DEPTH    = 1,
    parameter int KERNEL_HEIGHT = 5,
    parameter int KERNEL_WIDTH  = 5,
    parameter int STRIDE        = 1,
    parameter int PAD           = 0,
    parameter int PORT_NUM      = KERNEL_HEIGHT * KERNEL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PORT_NUM*ADDR_WIDTH-1:0] out_addr,
    output logic [PORT_NUM-1:0]            out_mask,
    output logic [7:0]                     out_depth,
    output logic [15:0]                    out_row,
    output logic [15:0]                    out_col,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    // state  | meaning
    // S_IDLE | waiting for start, counters parked at 0, no window presented
    // S_RUN  | a window is presented every cycle until the last one transfers

    localparam int OH_NUM = DATA_HEIGHT + 2 * PAD - KERNEL_HEIGHT;
    localparam int OW_NUM = DATA_WIDTH + 2 * PAD - KERNEL_WIDTH;
    localparam int OH     = (OH_NUM >= 0) ? OH_NUM / STRIDE + 1 : 0;
    localparam int OW     = (OW_NUM >= 0) ? OW_NUM / STRIDE + 1 : 0;
    localparam int PLANE  = DATA_HEIGHT * DATA_WIDTH;

    localparam longint TOTAL_WORDS = longint'(DATA_DEPTH) * longint'(PLANE);
    localparam longint ADDR_SPACE  = longint'(1) << ADDR_WIDTH;

    generate
        if (OH < 1 || OW < 1) begin : g_bad_out_size
            $error("conv_window_addr_gen: output map is empty for this geometry");
        end
        if (TOTAL_WORDS > ADDR_SPACE) begin : g_bad_addr_width
            $error("conv_window_addr_gen: feature map does not fit in ADDR_WIDTH");
        end
        if (STRIDE < 1 || DATA_DEPTH < 1 || DATA_DEPTH > 256) begin : g_bad_param
            $error("conv_window_addr_gen: STRIDE or DATA_DEPTH out of range");
        end
        if (PAD < 0 || PAD > KERNEL_HEIGHT - 1) begin : g_bad_pad
            $error("conv_window_addr_gen: PAD out of range");
        end
        if (PORT_NUM != KERNEL_HEIGHT * KERNEL_WIDTH) begin : g_bad_port_num
            $error("conv_window_addr_gen: PORT_NUM must equal KERNEL_HEIGHT*KERNEL_WIDTH");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ox_q, ox_d;
    logic [15:0] oy_q, oy_d;
    logic [7:0]  d_q, d_d;
    logic        done_q, done_d;

    logic ox_wrap, oy_wrap, d_wrap, last_win, xfer;

    assign ox_wrap  = (ox_q == 16'(OW - 1));
    assign oy_wrap  = (oy_q == 16'(OH - 1));
    assign d_wrap   = (d_q == 8'(DATA_DEPTH - 1));
    assign last_win = ox_wrap && oy_wrap && d_wrap;
    assign xfer     = (state_q == S_RUN) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        d_d     = d_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            ox_d    = '0;
            oy_d    = '0;
            d_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        ox_d    = '0;
                        oy_d    = '0;
                        d_d     = '0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (last_win) begin
                            state_d = S_IDLE;
                            ox_d    = '0;
                            oy_d    = '0;
                            d_d     = '0;
                            done_d  = 1'b1;
                        end else if (ox_wrap) begin
                            ox_d = '0;
                            if (oy_wrap) begin
                                oy_d = '0;
                                d_d  = d_q + 8'd1;
                            end else begin
                                oy_d = oy_q + 16'd1;
                            end
                        end else begin
                            ox_d = ox_q + 16'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Returns {in_bounds, address}; padding taps come back as all zeros.
    function automatic logic [ADDR_WIDTH:0] tap_geom(input logic [7:0]  d,
                                                     input logic [15:0] oy,
                                                     input logic [15:0] ox,
                                                     input int          t);
        logic signed [16:0] y_s;
        logic signed [16:0] x_s;
        int                 yi;
        int                 xi;
        int                 lin;
        y_s = 17'(int'(oy) * STRIDE - PAD + t / KERNEL_WIDTH);
        x_s = 17'(int'(ox) * STRIDE - PAD + t % KERNEL_WIDTH);
        yi  = int'(y_s);
        xi  = int'(x_s);
        if (yi >= 0 && yi < DATA_HEIGHT && xi >= 0 && xi < DATA_WIDTH) begin
            lin = int'(d) * PLANE + yi * DATA_WIDTH + xi;
            return {1'b1, ADDR_WIDTH'(lin)};
        end
        return '0;
    endfunction

    logic [PORT_NUM*ADDR_WIDTH-1:0] addr_v;
    logic [PORT_NUM-1:0]            mask_v;
    logic [ADDR_WIDTH:0]            geom;

    always_comb begin
        addr_v = '0;
        mask_v = '0;
        geom   = '0;
        if (state_q == S_RUN) begin
            for (int t = 0; t < PORT_NUM; t++) begin
                geom                                  = tap_geom(d_q, oy_q, ox_q, t);
                mask_v[t]                             = geom[ADDR_WIDTH];
                addr_v[t*ADDR_WIDTH +: ADDR_WIDTH]    = geom[ADDR_WIDTH-1:0];
            end
        end
    end

    assign out_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign out_last  = (state_q == S_RUN) && last_win;
    assign out_addr  = addr_v;
    assign out_mask  = mask_v;
    assign out_depth = d_q;
    assign out_row   = oy_q;
    assign out_col   = ox_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed bench for conv_window_addr_gen: a 6x6 k3 s1 p0 instance and a 5x5x2 k3 s2 p1 instance.
module tb_conv_window_addr_gen;

    localparam int AW = 16;
    localparam int PN = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            start_a, abort_a, ready_a;
    logic            valid_a, last_a, busy_a, done_a;
    logic [PN*AW-1:0] addr_a;
    logic [PN-1:0]   mask_a;
    logic [7:0]      depth_a;
    logic [15:0]     row_a, col_a;

    logic            start_b, abort_b, ready_b;
    logic            valid_b, last_b, busy_b, done_b;
    logic [PN*AW-1:0] addr_b;
    logic [PN-1:0]   mask_b;
    logic [7:0]      depth_b;
    logic [15:0]     row_b, col_b;

    conv_window_addr_gen #(
        .ADDR_WIDTH(AW), .DATA_HEIGHT(6), .DATA_WIDTH(6), .DATA_DEPTH(1),
        .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3), .STRIDE(1), .PAD(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_addr(addr_a), .out_mask(mask_a),
        .out_depth(depth_a), .out_row(row_a), .out_col(col_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    conv_window_addr_gen #(
        .ADDR_WIDTH(AW), .DATA_HEIGHT(5), .DATA_WIDTH(5), .DATA_DEPTH(2),
        .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3), .STRIDE(2), .PAD(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_addr(addr_b), .out_mask(mask_b),
        .out_depth(depth_b), .out_row(row_b), .out_col(col_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int m_addr(input int h, w, k, s, p, d, oy, ox, t);
        int y, x;
        y = oy * s - p + t / k;
        x = ox * s - p + t % k;
        if (y < 0 || y >= h || x < 0 || x >= w) return 0;
        return (d * h * w + y * w + x) & 32'hFFFF;
    endfunction

    function automatic int m_mask(input int h, w, k, s, p, oy, ox);
        int y, x, m;
        m = 0;
        for (int t = 0; t < k * k; t++) begin
            y = oy * s - p + t / k;
            x = ox * s - p + t % k;
            if (y >= 0 && y < h && x >= 0 && x < w) m |= (1 << t);
        end
        return m;
    endfunction

    task automatic chk_win(input string tag, input logic vld, input logic [PN*AW-1:0] addr,
                           input logic [PN-1:0] mask, input logic [7:0] dep,
                           input logic [15:0] row, input logic [15:0] col, input logic lst,
                           input int h, w, s, p, d, oy, ox, input bit exp_last);
        check({tag, ".valid"}, 32'(vld), 1);
        check({tag, ".depth"}, 32'(dep), d);
        check({tag, ".row"}, 32'(row), oy);
        check({tag, ".col"}, 32'(col), ox);
        check({tag, ".last"}, 32'(lst), 32'(exp_last));
        check({tag, ".mask"}, 32'(mask), m_mask(h, w, 3, s, p, oy, ox));
        for (int t = 0; t < PN; t++)
            check($sformatf("%s.tap%0d", tag, t), 32'(addr[t*AW +: AW]),
                  m_addr(h, w, 3, s, p, d, oy, ox, t));
    endtask

    task automatic chk_a(input string tag, input int idx);
        chk_win(tag, valid_a, addr_a, mask_a, depth_a, row_a, col_a, last_a,
                6, 6, 1, 0, 0, idx / 4, idx % 4, idx == 15);
    endtask

    int exp_first[PN] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int exp_lastw[PN] = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    int exp_b00[PN]   = '{0, 0, 0, 0, 0, 1, 0, 5, 6};
    logic [3:0] bp_pat = 4'b1001;

    initial begin
        int idx, cyc;
        logic [AW-1:0] held;
        rst_n   = 1'b0;
        start_a = 0; abort_a = 0; ready_a = 0;
        start_b = 0; abort_b = 0; ready_b = 0;
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(valid_a), 0);
        check("rst.busy", 32'(busy_a), 0);
        check("rst.done", 32'(done_a), 0);
        check("rst.last", 32'(last_a), 0);
        check("rst.addr_nz", 32'(addr_a != '0), 0);
        check("rst.mask", 32'(mask_a), 0);
        check("rst.rowcol", 32'({row_a, col_a}), 0);
        rst_n = 1'b1;

        // Full pass, out_ready held high
        @(negedge clk); start_a = 1; ready_a = 1;
        check("a.idle_valid", 32'(valid_a), 0);
        @(negedge clk); start_a = 0;
        check("a.first.busy", 32'(busy_a), 1);
        for (int t = 0; t < PN; t++)
            check($sformatf("a.first.tap%0d", t), 32'(addr_a[t*AW +: AW]), exp_first[t]);
        check("a.first.mask", 32'(mask_a), 32'h1FF);
        for (int i = 0; i < 16; i++) begin
            chk_a($sformatf("a.w%0d", i), i);
            check($sformatf("a.w%0d.done", i), 32'(done_a), 0);
            if (i == 15)
                for (int t = 0; t < PN; t++)
                    check($sformatf("a.lastw.tap%0d", t), 32'(addr_a[t*AW +: AW]), exp_lastw[t]);
            @(negedge clk);
        end
        check("a.end.valid", 32'(valid_a), 0);
        check("a.end.busy", 32'(busy_a), 0);
        check("a.end.done", 32'(done_a), 1);
        @(negedge clk);
        check("a.end.done_off", 32'(done_a), 0);

        // Backpressure with out_ready pattern 1,0,0,1
        start_a = 1; ready_a = 0;
        @(negedge clk); start_a = 0;
        idx = 0; cyc = 0; held = '0;
        while (idx < 16 && cyc < 100) begin
            chk_a($sformatf("bp.c%0d", cyc), idx);
            if (cyc > 0 && !ready_a)
                check($sformatf("bp.c%0d.hold", cyc), 32'(addr_a[4*AW +: AW]), 32'(held));
            held    = addr_a[4*AW +: AW];
            ready_a = bp_pat[cyc % 4];
            if (ready_a) idx++;
            @(negedge clk);
            cyc++;
        end
        check("bp.transfers", 32'(idx), 16);
        check("bp.cycles", 32'(cyc), 32);
        check("bp.end.valid", 32'(valid_a), 0);
        check("bp.end.done", 32'(done_a), 1);
        ready_a = 1;
        @(negedge clk);

        // Abort on the 5th window together with out_ready
        start_a = 1;
        @(negedge clk); start_a = 0;
        for (int i = 0; i < 4; i++) begin
            chk_a($sformatf("ab.w%0d", i), i);
            @(negedge clk);
        end
        chk_a("ab.w4", 4);
        abort_a = 1;
        @(negedge clk); abort_a = 0;
        check("ab.valid", 32'(valid_a), 0);
        check("ab.busy", 32'(busy_a), 0);
        check("ab.done", 32'(done_a), 0);
        check("ab.rowcol", 32'({row_a, col_a}), 0);
        @(negedge clk);
        check("ab.done_late", 32'(done_a), 0);
        start_a = 1;
        @(negedge clk); start_a = 0;
        chk_a("ab.restart", 0);

        // Reset mid-pass
        @(negedge clk);
        chk_a("rm.w1", 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rm.valid", 32'(valid_a), 0);
        check("rm.busy", 32'(busy_a), 0);
        check("rm.addr_nz", 32'(addr_a != '0), 0);
        check("rm.mask", 32'(mask_a), 0);
        check("rm.rowcol", 32'({depth_a, row_a, col_a}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rm.no_done", 32'(done_a), 0);
        start_a = 1;
        @(negedge clk); start_a = 0;
        for (int i = 0; i < 16; i++) begin
            chk_a($sformatf("rm.w%0d", i), i);
            start_a = (i == 5);
            @(negedge clk);
        end
        start_a = 0;
        check("rm.end.done", 32'(done_a), 1);
        check("rm.end.valid", 32'(valid_a), 0);

        // Stride 2, pad 1, two planes
        start_b = 1; ready_b = 1;
        @(negedge clk); start_b = 0;
        check("b.w0.hmask", 32'(mask_b), 32'h1B0);
        for (int t = 0; t < PN; t++)
            check($sformatf("b.w0.htap%0d", t), 32'(addr_b[t*AW +: AW]), exp_b00[t]);
        for (int i = 0; i < 18; i++) begin
            chk_win($sformatf("b.w%0d", i), valid_b, addr_b, mask_b, depth_b, row_b, col_b, last_b,
                    5, 5, 2, 1, i / 9, (i % 9) / 3, i % 3, i == 17);
            if (i == 4) begin
                check("b.w4.hmask", 32'(mask_b), 32'h1FF);
                check("b.w4.htap0", 32'(addr_b[0 +: AW]), 6);
            end
            if (i == 9) begin
                check("b.w9.hdepth", 32'(depth_b), 1);
                check("b.w9.hrowcol", 32'({row_b, col_b}), 0);
                check("b.w9.htap4", 32'(addr_b[4*AW +: AW]), 25);
            end
            @(negedge clk);
        end
        check("b.end.valid", 32'(valid_b), 0);
        check("b.end.done", 32'(done_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
